// File: rtl/fpga_synth_key_pio.sv
`default_nettype none
// ============================================================================
// Module   : fpga_synth_key_pio
// Purpose  : Avalon-MM slave input port for the synth's push-buttons and
//            switches. Each input bit is polarity-corrected, synchronised,
//            debounced and edge-detected. Press edges are latched in a
//            write-1-to-clear capture register that drives a maskable level
//            interrupt.
// Ports    : clk        - system clock
//            reset_n    - asynchronous active-low reset
//            address    - Avalon word address (0 DATA, 1 rsvd, 2 IRQMASK,
//                         3 EDGECAPTURE)
//            chipselect - Avalon select
//            write_n    - Avalon write strobe, active-low
//            writedata  - Avalon write data
//            in_port    - raw asynchronous button/switch inputs
//            readdata   - Avalon read data, zero-extended, zero-latency
//            irq        - level interrupt, active-high
// Revision : 1.0 - initial release
// ============================================================================
module fpga_synth_key_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int             c_CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] c_ADDR_DATA = 2'd0;
  localparam logic [1:0] c_ADDR_MASK = 2'd2;
  localparam logic [1:0] c_ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] w_in;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] w_stable_nxt;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;

  // Invert on entry so a pressed active-low key is seen as 1 everywhere else.
  assign w_in = in_port ^ {WIDTH{(ACTIVE_LOW != 0)}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_in;
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit debounce: the synchronised value must disagree with the accepted
  // value for DEBOUNCE_CYCLES consecutive cycles; any return to agreement
  // restarts the count.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic            w_stb_nxt;

    always_comb begin
      w_cnt_nxt = r_cnt;
      w_stb_nxt = r_stable[i];
      if (r_sync2[i] == r_stable[i]) begin
        w_cnt_nxt = '0;
      end else if (r_cnt == c_CNT_MAX) begin
        w_stb_nxt = r_sync2[i];
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt + c_CW'(1);
      end
    end

    assign w_stable_nxt[i] = w_stb_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= '0;
    end else begin
      r_stable <= w_stable_nxt;
    end
  end

  // Press edge is taken from the next-state value so capture lands on the
  // same clock edge that stable rises.
  assign w_rise = w_stable_nxt & ~r_stable;

  assign w_wr  = chipselect && !write_n;
  assign w_clr = (w_wr && (address == c_ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
      r_edge <= '0;
    end else begin
      if (w_wr && (address == c_ADDR_MASK)) begin
        r_mask <= writedata[WIDTH-1:0];
      end
      // A coincident new press beats the clear on the same bit.
      r_edge <= (r_edge & ~w_clr) | w_rise;
    end
  end

  // Purely from registers: no bus input reaches irq combinationally.
  assign irq = |(r_edge & r_mask);

  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        c_ADDR_DATA: readdata[WIDTH-1:0] = r_stable;
        c_ADDR_MASK: readdata[WIDTH-1:0] = r_mask;
        c_ADDR_EDGE: readdata[WIDTH-1:0] = r_edge;
        default:     readdata            = '0;
      endcase
    end
  end

  // Upper write-data bits have no destination.
  if (WIDTH < 32) begin : g_wd_unused
    logic w_unused_wdata;
    assign w_unused_wdata = ^writedata[31:WIDTH];
  end

endmodule
`default_nettype wire
